// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-timing helpers.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int unsigned sample_time(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-byte ready/valid holding register and
// single-cycle framing-error / overrun pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);

    if (SYMBOL_EDGE_TIME < 4) begin : gen_baud_check
        $fatal(1, "uart_receiver: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end

    logic           w_rx;
    logic           w_stop_sample;
    logic           w_byte_done;
    uart_rx_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]     r_idx;
    logic [7:0]     r_shift;
    logic [7:0]     r_data;
    logic           r_valid;
    logic           r_frame_error;
    logic           r_overrun;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (serial_in),
        .o_q   (w_rx)
    );

    assign w_stop_sample = (r_state == STOP) && (r_cnt == SYMBOL_LAST);
    assign w_byte_done   = w_stop_sample && w_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_rx) begin
                        r_cnt   <= '0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_cnt == SAMPLE_LAST) begin
                        if (w_rx) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            r_state <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == SYMBOL_LAST) begin
                        r_shift[r_idx] <= w_rx;
                        r_cnt          <= '0;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (r_cnt == SYMBOL_LAST) begin
                        r_cnt   <= '0;
                        // A low stop bit parks in BREAK so a held-low line cannot retrigger.
                        r_state <= w_rx ? IDLE : BREAK;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (w_rx) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data        <= 8'h00;
            r_valid       <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= w_stop_sample && !w_rx;
            r_overrun     <= 1'b0;
            if (w_byte_done) begin
                if (!r_valid || data_out_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && data_out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign frame_error    = r_frame_error;
    assign overrun        = r_overrun;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage (8N1, LSB first) feeding received bytes to the core's memory-mapped IO controller over a ready/valid handshake. It synchronises the raw `serial_in` pin, times each symbol with a cycle counter derived from clock and baud parameters, and holds one completed byte in an output register until the consumer takes it. It flags framing errors and overruns with single-cycle pulses so the IO controller can expose them as status bits.

## Interface
- `CLOCK_FREQ`, default 125_000_000: core clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in baud.
- `clk` input 1: core clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `serial_in` input 1: raw asynchronous RX pin; idle high.
- `data_out` output 8: received byte; meaningful only while `data_out_valid` is high.
- `data_out_valid` output 1: a byte is held and available.
- `data_out_ready` input 1: consumer accepts the byte on any cycle where both `data_out_valid` and `data_out_ready` are high.
- `frame_error` output 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` output 1: one-cycle pulse when a completed byte is dropped because the holding register is still full.

## Operation
- Constants:
  - `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` (integer division).
  - `SAMPLE_TIME = SYMBOL_EDGE_TIME / 2`.
  - Elaboration fails if `SYMBOL_EDGE_TIME < 4`.
  - Counter width is `$clog2(SYMBOL_EDGE_TIME)`.
- Input passes through a 2-FF synchronizer. Both FFs reset to 1. `rx` below means the synchronized value.
- State machine transitions:
  - **IDLE**: on `rx == 0`, clear the counter and go to START.
  - **START**: when counter reaches `SAMPLE_TIME-1`, sample `rx`.
    - `rx == 1`: false start; go to IDLE.
    - `rx == 0`: clear the counter and bit index, then go to DATA.
  - **DATA**: when counter reaches `SYMBOL_EDGE_TIME-1`, sample `rx` into shift-register bit `[index]` (LSB first) and clear the counter. After index 7, go to STOP.
  - **STOP**: when counter reaches `SYMBOL_EDGE_TIME-1`, sample `rx`.
    - `rx == 1`: byte complete; go to IDLE.
    - `rx == 0`: pulse `frame_error`, discard the byte, go to BREAK.
  - **BREAK**: wait for `rx == 1`, then go to IDLE. This prevents a held-low line from retriggering.
- Holding register behaviour on byte complete:
  - `data_out_valid == 0`: load the byte and set valid.
  - `data_out_valid == 1` and `data_out_ready == 1` in the same cycle: old byte is consumed, new byte is loaded, valid stays 1.
  - `data_out_valid == 1` and `data_out_ready == 0`: new byte is dropped, `overrun` pulses, held byte is unchanged.
- A handshake with no completion clears valid on the next edge. `data_out` holds its last value.
- The receiver keeps sampling while the holding register is full. Backpressure never stalls the line.

## Timing
- Reset values: `data_out = 8'h00`, `data_out_valid = 0`, `frame_error = 0`, `overrun = 0`, state IDLE, counter 0.
- Reset asserted mid-frame aborts reception on the next edge. Any held byte is lost.
- Pin to synchronized `rx` latency is 2 cycles.
- Sample points, counted from the first cycle `rx == 0` in IDLE:
  - Start bit: cycle `SAMPLE_TIME`.
  - Data bit *k*: cycle `SAMPLE_TIME + (k+1)*SYMBOL_EDGE_TIME`.
  - Stop bit: cycle `SAMPLE_TIME + 9*SYMBOL_EDGE_TIME`.
- `data_out_valid`, `frame_error` and `overrun` are registered. Each asserts on the edge following the stop-bit sample.
- The FSM is back in IDLE at the midpoint of the stop bit. A start bit arriving immediately after the stop bit is therefore caught.

## Structure
- Package `uart_pkg` holds:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t`.
  - Constant functions computing `SYMBOL_EDGE_TIME` and `SAMPLE_TIME` from clock and baud. These are shared with the future transmitter.
- One sub-module: `sync_2ff` (parameterised reset value), reused for other asynchronous pins.
- Everything else is a single module: FSM, counter, shift register, holding register.

## Test plan
Bench parameters: `CLOCK_FREQ = 1_000_000`, `BAUD_RATE = 100_000`, giving `SYMBOL_EDGE_TIME = 10` and `SAMPLE_TIME = 5`.
- **Single byte:** send 0xA5 with `data_out_ready = 0` -> `data_out = 8'hA5` and `data_out_valid` rises exactly 2+5+90+1 = 98 cycles after the pin falls. Valid then holds until ready pulses and clears the cycle after the handshake.
- **Back-to-back:** send 0x00, 0xFF, 0x3C with no idle gap and ready tied high -> three valid pulses with the bytes in order; no `frame_error`, no `overrun`.
- **Framing error:** send 0x55 with the stop bit low, hold the line low for 30 cycles, then send 0x12 -> `frame_error` pulses once with no valid. Reception resumes only after the line goes high, and 0x12 is received correctly.
- **Glitch / false start:** drive the pin low for 3 cycles -> FSM returns to IDLE; no valid, no error pulses.
- **Overrun and simultaneous completion:**
  - Hold ready low and send 0x11 then 0x22 -> `overrun` pulses once and `data_out` stays 0x11.
  - Repeat with ready asserted on the completion cycle of 0x22 -> 0x11 is consumed, 0x22 is loaded, valid stays 1.
- **Reset mid-frame:** assert `rst` during data bit 4 of a byte -> all outputs are 0 on the next edge. A subsequent byte 0x7E is received correctly.
